// File: rtl/cpu_types_pkg.sv
// Shared CPU types: bus words, instruction-cache address split,
// frame layout and fill FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W = 32 - ICACHE_IDX_W - 2;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t                   data;
    } icache_frame_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_frame_array.sv
// Direct-mapped frame storage: one async read port, one write port.
// Only valid bits are reset; tag/data are plain flops.
module icache_frame_array
    import cpu_types_pkg::*;
#(
    parameter  int SETS  = 16,
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = 32 - IDX_W - 2
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_valid,
    output logic [TAG_W-1:0] o_rd_tag,
    output word_t            o_rd_data,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  word_t            i_wr_data
);

    logic [SETS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tag  [SETS];
    word_t            r_data [SETS];

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with a one-word fill FSM.
// ICACHE_PERF_EN adds saturating hit/miss counters.
module icache_dm
    import cpu_types_pkg::*;
#(
    parameter  int SETS  = 16,
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = 32 - IDX_W - 2
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output logic  ihit,
    output word_t imemload,
    output logic  iREN,
    output word_t iaddr,
    input  logic  iwait,
    input  word_t iload
`ifdef ICACHE_PERF_EN
    ,
    output word_t hit_count,
    output word_t miss_count
`endif
);

    icache_state_t r_state;
    icache_state_t w_next;
    logic [29:0]   r_miss_addr;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_fidx;
    logic [TAG_W-1:0] w_ftag;
    logic             w_rd_valid;
    logic [TAG_W-1:0] w_rd_tag;
    word_t            w_rd_data;
    logic             w_hit;
    logic             w_miss_start;
    logic             w_fill_done;
    logic             w_unused_bytoff;

    assign w_idx  = imemaddr[IDX_W+1:2];
    assign w_tag  = imemaddr[31:IDX_W+2];
    assign w_fidx = r_miss_addr[IDX_W-1:0];
    assign w_ftag = r_miss_addr[29:IDX_W];

    assign w_unused_bytoff = ^imemaddr[1:0];

    assign w_hit = imemREN && (r_state == IDLE)
                && w_rd_valid && (w_rd_tag == w_tag);
    assign w_miss_start = (r_state == IDLE) && imemREN && !w_hit;
    assign w_fill_done  = (r_state == FILL) && !iwait;

    icache_frame_array #(
        .SETS(SETS)
    ) u_frames (
        .i_clk      (CLK),
        .i_nrst     (nRST),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_fill_done),
        .i_wr_idx   (w_fidx),
        .i_wr_tag   (w_ftag),
        .i_wr_data  (iload)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_miss_addr <= '0;
        end else begin
            r_state <= w_next;
            if (w_miss_start) begin
                r_miss_addr <= imemaddr[31:2];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        iREN   = 1'b0;
        iaddr  = '0;
        unique case (r_state)
            IDLE: begin
                if (w_miss_start) begin
                    w_next = FILL;
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = {r_miss_addr, 2'b00};
                if (!iwait) begin
                    w_next = IDLE;
                end
            end
        endcase
    end

    assign ihit     = w_hit;
    assign imemload = w_hit ? w_rd_data : '0;

`ifdef ICACHE_PERF_EN
    word_t r_hit_count;
    word_t r_miss_count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss_start && (r_miss_count != '1)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed self-checking bench for icache_dm with a simple
// wait-state memory responder.
module tb_icache_dm;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST;
    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;
`ifdef ICACHE_PERF_EN
    word_t hit_count;
    word_t miss_count;
`endif

    int total = 0;
    int bad   = 0;
    int lat   = 2;
    int wcnt  = 0;

    icache_dm dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload)
`ifdef ICACHE_PERF_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic word_t mem_word(word_t a);
        case (a)
            32'h0000_0000: mem_word = 32'h2001_0005;
            32'h0000_0004: mem_word = 32'hAAAA_AAAA;
            32'h0000_0044: mem_word = 32'hBBBB_BBBB;
            32'h0000_0010: mem_word = 32'h1111_0010;
            32'h0000_0020: mem_word = 32'h2222_0020;
            default:       mem_word = a ^ 32'h5A5A_0000;
        endcase
    endfunction

    // Memory holds iwait high for 'lat' cycles of each request.
    always @(posedge CLK) begin
        if (!iREN) wcnt <= lat;
        else if (wcnt != 0) wcnt <= wcnt - 1;
    end

    assign iwait = iREN && (wcnt != 0);
    assign iload = (iREN && !iwait) ? mem_word(iaddr) : '0;

    task automatic cyc;
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_hit(output int n);
        n = 0;
        while (ihit !== 1'b1 && n < 100) begin
            cyc();
            n++;
        end
    endtask

    task automatic test_reset;
        nRST = 1'b0;
        imemREN = 1'b0;
        imemaddr = '0;
        repeat (2) @(posedge CLK);
        #2;
        total++;
        if (ihit !== 1'b0) begin
            bad++;
            $display("FAIL rst_ihit got=%b want=0", ihit);
        end
        total++;
        if (imemload !== 32'h0) begin
            bad++;
            $display("FAIL rst_load got=%h want=0", imemload);
        end
        total++;
        if (iREN !== 1'b0) begin
            bad++;
            $display("FAIL rst_iren got=%b want=0", iREN);
        end
        total++;
        if (iaddr !== 32'h0) begin
            bad++;
            $display("FAIL rst_iaddr got=%h want=0", iaddr);
        end
        nRST = 1'b1;
    endtask

    task automatic test_miss_fill;
        logic eh, er;
        imemREN = 1'b1;
        imemaddr = 32'h0;
        #1;
        for (int c = 0; c <= 4; c++) begin
            eh = (c == 4);
            er = (c >= 1) && (c <= 3);
            total++;
            if ({ihit, iREN} !== {eh, er}) begin
                bad++;
                $display("FAIL fill_c%0d hit/iren got=%b%b want=%b%b",
                         c, ihit, iREN, eh, er);
            end
            if (er) begin
                total++;
                if (iaddr !== 32'h0) begin
                    bad++;
                    $display("FAIL fill_iaddr_c%0d got=%h want=0",
                             c, iaddr);
                end
            end
            if (c == 4) begin
                total++;
                if (imemload !== 32'h2001_0005) begin
                    bad++;
                    $display("FAIL fill_load got=%h want=20010005",
                             imemload);
                end
            end
            if (c < 4) cyc();
        end
    endtask

    task automatic test_rehit;
        cyc();
        total++;
        if (ihit !== 1'b1 || imemload !== 32'h2001_0005) begin
            bad++;
            $display("FAIL rehit got=%b/%h want=1/20010005",
                     ihit, imemload);
        end
        total++;
        if (iREN !== 1'b0) begin
            bad++;
            $display("FAIL rehit_iren got=%b want=0", iREN);
        end
`ifdef ICACHE_PERF_EN
        total++;
        if (miss_count !== 32'd1) begin
            bad++;
            $display("FAIL perf_miss got=%0d want=1", miss_count);
        end
        total++;
        if (hit_count !== 32'd1) begin
            bad++;
            $display("FAIL perf_hit got=%0d want=1", hit_count);
        end
`endif
    endtask

    task automatic test_conflict;
        word_t addrs [3] = '{32'h04, 32'h44, 32'h04};
        word_t datas [3] = '{32'hAAAA_AAAA, 32'hBBBB_BBBB,
                             32'hAAAA_AAAA};
        int n;
        for (int i = 0; i < 3; i++) begin
            imemaddr = addrs[i];
            #1;
            total++;
            if (ihit !== 1'b0) begin
                bad++;
                $display("FAIL conf_miss%0d got=%b want=0", i, ihit);
            end
            wait_hit(n);
            total++;
            if (n != 4 || imemload !== datas[i]) begin
                bad++;
                $display("FAIL conf_fill%0d got=%0d/%h want=4/%h",
                         i, n, imemload, datas[i]);
            end
        end
    endtask

    task automatic test_addr_change;
        int n;
        logic ok;
        imemaddr = 32'h10;
        #1;
        total++;
        if (ihit !== 1'b0) begin
            bad++;
            $display("FAIL chg_miss got=%b want=0", ihit);
        end
        cyc();
        imemaddr = 32'h20;
        #1;
        n = 0;
        ok = 1'b1;
        while (iREN === 1'b1 && n < 100) begin
            if (iaddr !== 32'h10) ok = 1'b0;
            cyc();
            n++;
        end
        total++;
        if (!ok || n != 3) begin
            bad++;
            $display("FAIL chg_fill ok/cycles got=%b/%0d want=1/3",
                     ok, n);
        end
        total++;
        if (ihit !== 1'b0) begin
            bad++;
            $display("FAIL chg_miss20 got=%b want=0", ihit);
        end
        wait_hit(n);
        total++;
        if (n != 4 || imemload !== 32'h2222_0020) begin
            bad++;
            $display("FAIL chg_fill20 got=%0d/%h want=4/22220020",
                     n, imemload);
        end
        imemaddr = 32'h10;
        #1;
        total++;
        if (ihit !== 1'b1 || imemload !== 32'h1111_0010) begin
            bad++;
            $display("FAIL chg_hit10 got=%b/%h want=1/11110010",
                     ihit, imemload);
        end
    endtask

    task automatic test_reset_mid_fill;
        int n;
        lat = 20;
        imemaddr = 32'h08;
        #1;
        cyc();
        total++;
        if (iREN !== 1'b1) begin
            bad++;
            $display("FAIL mid_iren got=%b want=1", iREN);
        end
        nRST = 1'b0;
        #1;
        total++;
        if ({iREN, ihit} !== 2'b00 || iaddr !== 32'h0) begin
            bad++;
            $display("FAIL mid_rst iren/hit/iaddr got=%b%b/%h want=00/0",
                     iREN, ihit, iaddr);
        end
        cyc();
        nRST = 1'b1;
        lat = 2;
        #1;
        total++;
        if (ihit !== 1'b0) begin
            bad++;
            $display("FAIL mid_remiss got=%b want=0", ihit);
        end
        wait_hit(n);
        total++;
        if (n != 4 || imemload !== 32'h5A5A_0008) begin
            bad++;
            $display("FAIL mid_refill got=%0d/%h want=4/5a5a0008",
                     n, imemload);
        end
    endtask

    task automatic test_ren_low;
        imemREN = 1'b0;
        #1;
        total++;
        if ({ihit, iREN} !== 2'b00 || imemload !== 32'h0) begin
            bad++;
            $display("FAIL renlow hit/iren/load got=%b%b/%h want=00/0",
                     ihit, iREN, imemload);
        end
        cyc();
        total++;
        if (iREN !== 1'b0) begin
            bad++;
            $display("FAIL renlow_iren got=%b want=0", iREN);
        end
        imemREN = 1'b1;
        #1;
        total++;
        if (ihit !== 1'b1 || imemload !== 32'h5A5A_0008) begin
            bad++;
            $display("FAIL renlow_hit got=%b/%h want=1/5a5a0008",
                     ihit, imemload);
        end
    endtask

    initial begin
        test_reset();
        test_miss_fill();
        test_rehit();
        test_conflict();
        test_addr_change();
        test_reset_mid_fill();
        test_ren_low();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the datapath's instruction port (imemREN/imemaddr/ihit/imemload) and the memory controller's instruction port.
- Hits return the instruction combinationally in the same cycle, so the single-cycle datapath advances PC only on ihit.
- Misses run a small fill FSM that fetches one word from memory and installs it. The hit returns on the next cycle.

Parameters:
- SETS, 16, number of frames; power of two, ≥2.
- IDX_W, $clog2(SETS), index width; derived, not overridden.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- imemREN  input  1  datapath instruction read request.
- imemaddr  input  32  datapath instruction byte address; word aligned.
- ihit  output  1  instruction valid this cycle.
- imemload  output  32  instruction word; valid only when ihit=1.
- iREN  output  1  memory read request.
- iaddr  output  32  memory word address.
- iwait  input  1  memory busy; iload is valid in a cycle where iREN=1 and iwait=0.
- iload  input  32  memory read data.

Behaviour:
- Address split: bytoff=[1:0] (ignored), idx=[IDX_W+1:2], tag=[31:IDX_W+2].
- Storage per frame: valid bit, tag, 32-bit data. Only valid bits need reset; tag/data arrays may be non-reset flops.
- Hit: ihit = imemREN & state==IDLE & valid[idx] & tag[idx]==tag(imemaddr).
  - imemload = data[idx] when ihit=1, else 32'h0.
- FSM states: IDLE, FILL.
- IDLE:
  - imemREN=1 and no hit -> latch imemaddr into miss_addr; next state FILL.
  - Otherwise stay in IDLE.
  - iREN=0, iaddr=0.
- FILL:
  - iREN=1, iaddr={miss_addr[31:2],2'b00}, ihit=0.
  - iwait=1: hold in FILL.
  - iwait=0: write data/tag of frame idx(miss_addr) with iload and tag(miss_addr); set valid; next state IDLE.
  - The write takes effect at the clock edge, so the datapath hits in the first IDLE cycle if the address is unchanged.
  - Fill latency: 1 cycle miss detect + N memory cycles + 1 hit cycle.
- Fill always runs to completion once started. Changes to imemaddr or imemREN dropping during FILL do not abort or redirect it.
- Conflict miss: the same idx with a different tag overwrites the frame; no replacement choice.
- There is no write path; the cache is never dirty. Self-modifying code is out of scope.
- Reset (any time, including mid-FILL):
  - state=IDLE, all valid=0, miss_addr=0.
  - Outputs go to ihit=0, imemload=0, iREN=0, iaddr=0 immediately (asynchronous).
  - A fill interrupted by reset is discarded.
- imemREN=0 in IDLE: ihit=0, no memory traffic.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- Defined: adds outputs hit_count and miss_count (both 32-bit).
  - hit_count increments on each cycle with ihit=1.
  - miss_count increments on each IDLE->FILL transition.
  - Both saturate at 32'hFFFFFFFF and reset to 0 on nRST.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- cpu_types_pkg (shared package) gets:
  - typedef icachef_t: packed struct {tag, idx, bytoff} sized from SETS=16.
  - typedef icache_frame_t: {valid, tag, data}.
  - enum icache_state_t {IDLE, FILL}.
- The word_t typedef from cpu_types_pkg is reused for all 32-bit buses.
- One natural sub-module: icache_frame_array (valid/tag/data storage: index read port, write-enable/index/tag/data write port, async valid clear). The FSM and hit logic stay in icache_dm.

Test Plan:
- Reset then imemREN=1, imemaddr=0x0000_0000, memory returns 0x2001_0005 after 2 iwait cycles -> ihit=0 in cycles 0–3, iREN=1 with iaddr=0 in cycles 1–3, ihit=1 with imemload=0x2001_0005 in cycle 4.
- Re-read 0x0000_0000 after fill -> ihit=1 the same cycle, iREN=0, miss_count unchanged (PERF_EN build).
- Conflict: fill 0x0000_0004 (data 0xAAAA_AAAA), then read 0x0000_0044 (same idx 1, data 0xBBBB_BBBB) -> miss and refill; reading 0x0000_0004 again misses and returns 0xAAAA_AAAA.
- Address changes from 0x10 to 0x20 while in FILL for 0x10 -> fill completes to idx 4 with tag of 0x10, then 0x20 misses and fills idx 8; 0x10 then hits.
- Assert nRST during FILL (iwait=1) -> iREN drops immediately, and after release a read of the same address misses again (valid cleared).
- imemREN=0 with a valid cached address -> ihit=0, imemload=0, no iREN.
